// File: rtl/nibble_serialiser.sv
// nibble_serialiser: parallel-in, serial-out unload path for a register word.
// A WIDTH-bit word is captured on an active-low load strobe while idle and
// shifted out LSB first, one bit per clock, flagged by svalid.
//
// Ports:
//   clk     in            rising-edge clock
//   reset   in            asynchronous active-low reset
//   load    in            active-low load strobe, level-sampled
//   data    in  [WIDTH]   word captured when load is accepted
//   ready   out           high in IDLE (a low load will be accepted)
//   sout    out           serial data, LSB first (registered)
//   svalid  out           high while sout carries a data or parity bit
//   done    out           one-cycle pulse on the first IDLE cycle after a word
//
// Build option: define SERIALISER_PARITY_EN to append one even-parity bit
// (^data of the captured word) after the last data bit.

module nibble_serialiser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             sout,
    output logic             svalid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SERIALISER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             sout_q,   sout_d;
    logic             svalid_q, svalid_d;
    logic             done_q,   done_d;
`ifdef SERIALISER_PARITY_EN
    logic             par_q,    par_d;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = 1'b0;
        svalid_d = 1'b0;
        done_d   = 1'b0;
`ifdef SERIALISER_PARITY_EN
        par_d    = par_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!load) begin
                    // Bit 0 goes straight to the output register, so
                    // the shifter only holds the remaining bits.
                    state_d  = ST_SHIFT;
                    shreg_d  = {1'b0, data[WIDTH-1:1]};
                    cnt_d    = '0;
                    sout_d   = data[0];
                    svalid_d = 1'b1;
`ifdef SERIALISER_PARITY_EN
                    par_d    = ^data;
`endif
                end
            end

            ST_SHIFT: begin
                // cnt_q is the index of the bit currently on sout.
                if (cnt_q == LAST) begin
`ifdef SERIALISER_PARITY_EN
                    state_d  = ST_PARITY;
                    sout_d   = par_q;
                    svalid_d = 1'b1;
`else
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
`endif
                end else begin
                    shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                    sout_d   = shreg_q[0];
                    svalid_d = 1'b1;
                end
            end

`ifdef SERIALISER_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIALISER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sout_q   <= sout_d;
            svalid_q <= svalid_d;
            done_q   <= done_d;
`ifdef SERIALISER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign sout   = sout_q;
    assign svalid = svalid_q;
    assign done   = done_q;

endmodule
